// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares one board LED between NUM_REQ requesters.
//
// A round-robin arbiter picks a pending requester and a timing sequencer
// plays its blink pattern (on ticks, off ticks, blink count) on o_led. A
// timing tick is PRESCALE i_clk cycles long.
//
// Ports:
//   i_clk       system clock
//   i_resetn    asynchronous active-low reset
//   i_req       request level per requester
//   i_on_time   LED-on ticks, requester k at [k*TIME_W +: TIME_W]
//   i_off_time  LED-off ticks, same packing
//   i_count     number of on/off blinks, requester k at [k*CNT_W +: CNT_W]
//   i_abort     (only with LED_BLINK_ARB_ABORT_EN) cut the running sequence short
//   o_grant     one-hot owner of the LED
//   o_done      one-cycle one-hot pulse when the owner's pattern finishes
//   o_busy      sequence in progress
//   o_led       LED drive, 1 = lit
//
// Build option: define LED_BLINK_ARB_ABORT_EN to add the i_abort port.

module led_blink_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PRESCALE = 33333,
    parameter int unsigned TIME_W   = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*TIME_W-1:0]   i_on_time,
    input  logic [NUM_REQ*TIME_W-1:0]   i_off_time,
    input  logic [NUM_REQ*CNT_W-1:0]    i_count,
`ifdef LED_BLINK_ARB_ABORT_EN
    input  logic                        i_abort,
`endif
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [NUM_REQ-1:0]          o_done,
    output logic                        o_busy,
    output logic                        o_led
);

    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic                led_q, led_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [TIME_W-1:0]   on_q, on_d;
    logic [TIME_W-1:0]   off_q, off_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TIME_W-1:0]   phase_q, phase_d;

    logic                abort;
`ifdef LED_BLINK_ARB_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + IW1'(i);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!pick_found && i_req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // Fields of the candidate requester.
    logic [TIME_W-1:0] sel_on, sel_off;
    logic [CNT_W-1:0]  sel_cnt;

    always_comb begin
        sel_on  = '0;
        sel_off = '0;
        sel_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IW'(k)) begin
                sel_on  = i_on_time[k*TIME_W +: TIME_W];
                sel_off = i_off_time[k*TIME_W +: TIME_W];
                sel_cnt = i_count[k*CNT_W +: CNT_W];
            end
        end
    end

    logic              tick;
    logic [TIME_W-1:0] phase_end;

    assign tick      = (presc_q == PW'(PRESCALE - 1));
    assign phase_end = (state_q == StOn) ? on_q - 1'b1 : off_q - 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        led_d   = led_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        on_d    = on_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        phase_d = phase_q;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    grant_d = ONE << pick_idx;
                    busy_d  = 1'b1;
                    // Zero times are stretched to one tick.
                    on_d    = (sel_on == '0) ? TIME_W'(1) : sel_on;
                    off_d   = (sel_off == '0) ? TIME_W'(1) : sel_off;
                    cnt_d   = sel_cnt;
                    presc_d = '0;
                    phase_d = '0;
                    if (sel_cnt == '0) begin
                        state_d = StDone;
                        led_d   = 1'b0;
                    end else begin
                        state_d = StOn;
                        led_d   = 1'b1;
                    end
                end
            end

            StOn, StOff: begin
                if (abort) begin
                    state_d = StDone;
                    led_d   = 1'b0;
                end else begin
                    // Prescaler free-runs across phases so phases never drift.
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (phase_q == phase_end) begin
                            phase_d = '0;
                            if (state_q == StOn) begin
                                state_d = StOff;
                                led_d   = 1'b0;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                                if (cnt_q == CNT_W'(1)) begin
                                    state_d = StDone;
                                end else begin
                                    state_d = StOn;
                                    led_d   = 1'b1;
                                end
                            end
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
            end

            StDone: begin
                done_d  = grant_q;
                grant_d = '0;
                busy_d  = 1'b0;
                led_d   = 1'b0;
                state_d = StIdle;
                ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            on_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            on_q    <= on_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    assign o_grant = grant_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed testbench for led_blink_arbiter (NUM_REQ=4, PRESCALE=4).
// Inputs change and outputs are sampled on the falling clock edge. Sample i
// of a capture is taken just after the i-th rising edge following the grant
// edge (sample 0 = right after the grant edge).

module tb_led_blink_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TW   = 16;
    localparam int unsigned CW   = 8;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ*TW-1:0] on_time;
    logic [NREQ*TW-1:0] off_time;
    logic [NREQ*CW-1:0] count;
    logic             abort;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic             led;

    int checks;
    int errors;

    logic [63:0]     led_tr, done_tr, busy_tr;
    logic [NREQ-1:0] grant0, done_val;

    led_blink_arbiter #(
        .NUM_REQ  (NREQ),
        .PRESCALE (4),
        .TIME_W   (TW),
        .CNT_W    (CW)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (rst_n),
        .i_req      (req),
        .i_on_time  (on_time),
        .i_off_time (off_time),
        .i_count    (count),
`ifdef LED_BLINK_ARB_ABORT_EN
        .i_abort    (abort),
`endif
        .o_grant    (grant),
        .o_done     (done),
        .o_busy     (busy),
        .o_led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int k, input logic [TW-1:0] on_t, input logic [TW-1:0] off_t,
                              input logic [CW-1:0] cnt);
        on_time[k*TW +: TW]  = on_t;
        off_time[k*TW +: TW] = off_t;
        count[k*CW +: CW]    = cnt;
    endtask

    task automatic set_all(input logic [TW-1:0] on_t, input logic [TW-1:0] off_t,
                           input logic [CW-1:0] cnt);
        for (int k = 0; k < NREQ; k++) set_fields(k, on_t, off_t, cnt);
    endtask

    // Records led/done/busy for n samples; after sample 0 drives req_after and
    // optionally rewrites every field to (c_on, c_off, c_cnt).
    task automatic capture(input int n, input logic [NREQ-1:0] req_after, input logic chg,
                           input logic [TW-1:0] c_on, input logic [TW-1:0] c_off,
                           input logic [CW-1:0] c_cnt);
        led_tr   = '0;
        done_tr  = '0;
        busy_tr  = '0;
        grant0   = '0;
        done_val = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            led_tr  = led_tr  | (64'(led)   << i);
            done_tr = done_tr | (64'(|done) << i);
            busy_tr = busy_tr | (64'(busy)  << i);
            if (|done) done_val = done;
            if (i == 0) begin
                grant0 = grant;
                req    = req_after;
                if (chg) set_all(c_on, c_off, c_cnt);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy && done == '0) break;
            @(negedge clk);
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    logic [NREQ-1:0] rr_grants [5];
    logic [NREQ-1:0] rr_dones  [4];
    logic [NREQ-1:0] rr_exp    [5];
    int              rr_idx    [5];
    int              ng, nd;
    logic [NREQ-1:0] prev_grant;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req      = '0;
        abort    = 1'b0;
        on_time  = '0;
        off_time = '0;
        count    = '0;
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single blink, req[1]: on=2 (8 cyc), off=3 (12 cyc), count=1.
        // DONE state at sample 20, o_done at sample 21; req dropped mid-sequence.
        set_fields(1, 16'd2, 16'd3, 8'd1);
        req = 4'b0010;
        capture(24, 4'b0000, 1'b0, '0, '0, '0);
        check("single_grant", 64'(grant0), 64'h2);
        check("single_led", led_tr, 64'h0000_00FF);
        check("single_busy", busy_tr, 64'h001F_FFFF);
        check("single_done", done_tr, 64'h0020_0000);
        check("single_done_val", 64'(done_val), 64'h2);

        // Multi blink, req[0]: three 4-cycle pulses with 4-cycle gaps.
        set_fields(0, 16'd1, 16'd1, 8'd3);
        req = 4'b0001;
        capture(28, 4'b0000, 1'b0, '0, '0, '0);
        check("multi_grant", 64'(grant0), 64'h1);
        check("multi_led", led_tr, 64'h0000_0F0F_0F);
        check("multi_busy", busy_tr, 64'h01FF_FFFF);
        check("multi_done", done_tr, 64'h0200_0000);
        check("multi_done_val", 64'(done_val), 64'h1);

        // count=0, req[2]: no LED, busy for one cycle, done on the next edge.
        set_fields(2, 16'd5, 16'd5, 8'd0);
        req = 4'b0100;
        capture(6, 4'b0000, 1'b0, '0, '0, '0);
        check("cnt0_grant", 64'(grant0), 64'h4);
        check("cnt0_led", led_tr, 64'h0);
        check("cnt0_busy", busy_tr, 64'h1);
        check("cnt0_done", done_tr, 64'h2);
        check("cnt0_done_val", 64'(done_val), 64'h4);

        // on=0, req[3]: on phase stretched to one tick (4 cycles).
        set_fields(3, 16'd0, 16'd1, 8'd1);
        req = 4'b1000;
        capture(12, 4'b0000, 1'b0, '0, '0, '0);
        check("on0_grant", 64'(grant0), 64'h8);
        check("on0_led", led_tr, 64'hF);
        check("on0_done", done_tr, 64'h200);

        // Field change after grant: req[1] on=2 off=1 count=2, then fields
        // rewritten to 5/5/7 -- timing must follow the latched values.
        set_fields(1, 16'd2, 16'd1, 8'd2);
        req = 4'b0010;
        capture(28, 4'b0000, 1'b1, 16'd5, 16'd5, 8'd7);
        check("chg_grant", 64'(grant0), 64'h2);
        check("chg_led", led_tr, 64'h000F_F0FF);
        check("chg_busy", busy_tr, 64'h01FF_FFFF);
        check("chg_done", done_tr, 64'h0200_0000);
        wait_idle("chg_idle");

        // Asynchronous reset in the middle of ON.
        set_fields(0, 16'd3, 16'd1, 8'd2);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        check("arst_pre_led", 64'(led), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", 64'(led), 64'h0);
        check("arst_grant", 64'(grant), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        check("arst_done_held", 64'(done), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_done_after", 64'(done), 64'h0);
        check("arst_busy_after", 64'(busy), 64'h0);

        // Round-robin with all requests held, count=1 (10 cycles per owner).
        set_all(16'd1, 16'd1, 8'd1);
        req        = 4'b1111;
        ng         = 0;
        nd         = 0;
        prev_grant = '0;
        for (int c = 0; c < 120 && ng < 5; c++) begin
            @(negedge clk);
            if (grant != '0 && prev_grant == '0) begin
                rr_grants[ng] = grant;
                rr_idx[ng]    = c;
                ng++;
                if (ng == 5) req = '0;
            end
            if (done != '0 && nd < 4) begin
                rr_dones[nd] = done;
                nd++;
            end
            prev_grant = grant;
        end
        check("rr_grant_count", 64'(ng), 64'd5);
        check("rr_done_count", 64'(nd), 64'd4);
        for (int i = 0; i < ng; i++) check($sformatf("rr_grant%0d", i), 64'(rr_grants[i]),
                                           64'(rr_exp[i]));
        for (int i = 0; i < nd; i++) check($sformatf("rr_done%0d", i), 64'(rr_dones[i]),
                                           64'(rr_exp[i]));
        if (ng >= 2) check("rr_gap", 64'(rr_idx[1] - rr_idx[0]), 64'd10);
        wait_idle("rr_idle");

`ifdef LED_BLINK_ARB_ABORT_EN
        // Abort during OFF of a count=5 sequence; req[2] is served next.
        set_fields(1, 16'd1, 16'd2, 8'd5);
        set_fields(2, 16'd1, 16'd1, 8'd1);
        req = 4'b0110;
        @(negedge clk);
        check("abort_grant", 64'(grant), 64'h2);
        req = 4'b0100;
        repeat (5) @(negedge clk);
        check("abort_in_off", 64'(led), 64'h0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_wait", 64'(done), 64'h0);
        check("abort_grant_hold", 64'(grant), 64'h2);
        @(negedge clk);
        check("abort_done", 64'(done), 64'h2);
        check("abort_grant_clr", 64'(grant), 64'h0);
        @(negedge clk);
        check("abort_next_grant", 64'(grant), 64'h4);
        check("abort_next_led", 64'(led), 64'h1);
        req = 4'b0000;
        wait_idle("abort_idle");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
